times_table_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one registered 3x3-bit `times_table` multiplier between two independent requesters. Each requester presents an operand pair with a valid/ready handshake; the arbiter grants one request per cycle, round-robin, drives the multiplier's `enable`/`a`/`b`, and tracks in-flight operations. It returns each product to the requester that issued it as a one-cycle response pulse, and keeps a per-port completion count. It sits between the exercise-level requesters and the `times_table` instance; the multiplier is instantiated outside this block.

---
 rtl/times_table_arbiter_if.sv | 56 +++++
 rtl/times_table_arbiter.sv | 129 ++++++++++++
 tb/tb_times_table_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/times_table_arbiter_if.sv
`timescale 1ns/1ps
// times_table_arbiter_if
// Bundles the two requester ports, the two response ports, the multiplier
// drive/return path and the per-port completion counters of the
// times_table_arbiter.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is a pure function of the current
// valids and the arbiter's last grant, so a requester raises valid without
// waiting for ready. It then keeps a/b stable until the transfer happens.
// Responses (rspN_valid) are single-cycle pulses with no back-pressure.
//
// Modports:
//   slave  - the arbiter's view: takes requests and mul_result, drives
//            everything else.
//   master - the environment's view: requesters, multiplier, observers.
interface times_table_arbiter_if;
  logic       req0_valid;
  logic [2:0] req0_a;
  logic [2:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [2:0] req1_a;
  logic [2:0] req1_b;
  logic       req1_ready;
  logic       rsp0_valid;
  logic [5:0] rsp0_result;
  logic       rsp1_valid;
  logic [5:0] rsp1_result;
  logic       mul_enable;
  logic [2:0] mul_a;
  logic [2:0] mul_b;
  logic [5:0] mul_result;
  logic [7:0] done0_cnt;
  logic [7:0] done1_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output mul_enable, mul_a, mul_b,
    output done0_cnt, done1_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  mul_enable, mul_a, mul_b,
    input  done0_cnt, done1_cnt
  );
endinterface

// File: rtl/times_table_arbiter.sv
`timescale 1ns/1ps
// times_table_arbiter
// Shares one registered 3x3-bit multiplier between two requesters. A
// round-robin arbiter grants one request per cycle and drives the multiplier
// directly. A tag pipeline as deep as the multiplier latency remembers which
// port issued each operation. The product is returned to that port as a
// one-cycle pulse, and a per-port completion counter is kept.
//
// Parameters:
//   MUL_LATENCY - edges from issue to a valid mul_result (legal range 1..4).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - times_table_arbiter_if.slave: requests, responses, multiplier
//           drive/return, completion counters
module times_table_arbiter #(
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  times_table_arbiter_if.slave  bus
);

  logic                   last_grant;
  logic                   grant0;
  logic                   grant1;
  logic                   accept;
  logic                   accept_id;
  logic [MUL_LATENCY-1:0] tag_valid;
  logic [MUL_LATENCY-1:0] tag_id;
  logic                   last_valid;
  logic                   last_id;
  logic                   rsp0_valid_q;
  logic                   rsp1_valid_q;
  logic [5:0]             rsp0_result_q;
  logic [5:0]             rsp1_result_q;
  logic [7:0]             done0_q;
  logic [7:0]             done1_q;

  // Round robin: an uncontested port always wins. When both ports request,
  // the port that did not win the last accepted grant wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  // A grant implies valid, so every grant is an acceptance.
  assign accept    = grant0 | grant1;
  assign accept_id = grant1;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Multiplier drive. Operands are forced to zero when idle.
  always_comb begin
    bus.mul_enable = accept;
    bus.mul_a      = 3'd0;
    bus.mul_b      = 3'd0;
    if (grant0) begin
      bus.mul_a = bus.req0_a;
      bus.mul_b = bus.req0_b;
    end else if (grant1) begin
      bus.mul_a = bus.req1_a;
      bus.mul_b = bus.req1_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= accept_id;
    end
  end

  // Tag pipeline runs in lockstep with the multiplier. Stage 0 is written on
  // the issue edge, so the last stage lines up with the edge where mul_result
  // holds that product. Reset clears all valids, which drops in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= accept;
      tag_id[0]    <= accept_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign last_valid = tag_valid[MUL_LATENCY-1];
  assign last_id    = tag_id[MUL_LATENCY-1];

  // Response registers. A non-responding port keeps its last result. The
  // counter steps on the same edge that raises the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 6'd0;
      rsp1_result_q <= 6'd0;
      done0_q       <= 8'd0;
      done1_q       <= 8'd0;
    end else begin
      rsp0_valid_q <= last_valid & ~last_id;
      rsp1_valid_q <= last_valid & last_id;
      if (last_valid && !last_id) begin
        rsp0_result_q <= bus.mul_result;
        done0_q       <= done0_q + 8'd1;
      end
      if (last_valid && last_id) begin
        rsp1_result_q <= bus.mul_result;
        done1_q       <= done1_q + 8'd1;
      end
    end
  end

  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.done0_cnt   = done0_q;
  assign bus.done1_cnt   = done1_q;

endmodule

// File: tb/tb_times_table_arbiter.sv
`timescale 1ns/1ps
// tb_times_table_arbiter
// Directed bench for times_table_arbiter. dut_a uses the default latency of 1.
// dut_b uses latency 3. Each instance is paired with a matching registered
// multiplier model.
module tb_times_table_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [5:0] exp_q[$];

  times_table_arbiter_if ia();
  times_table_arbiter_if ib();

  times_table_arbiter #(.MUL_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  times_table_arbiter #(.MUL_LATENCY(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- multiplier models ----------------
  logic [5:0] ma_pipe;
  logic [5:0] mb_pipe [3];

  always_ff @(posedge clk) begin
    ma_pipe <= ia.mul_enable ? ({3'b0, ia.mul_a} * {3'b0, ia.mul_b}) : 6'd0;
  end
  assign ia.mul_result = ma_pipe;

  always_ff @(posedge clk) begin
    mb_pipe[0] <= ib.mul_enable ? ({3'b0, ib.mul_a} * {3'b0, ib.mul_b}) : 6'd0;
    mb_pipe[1] <= mb_pipe[0];
    mb_pipe[2] <= mb_pipe[1];
  end
  assign ib.mul_result = mb_pipe[2];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.req0_valid = 1'b0; ia.req0_a = 3'd0; ia.req0_b = 3'd0;
    ia.req1_valid = 1'b0; ia.req1_a = 3'd0; ia.req1_b = 3'd0;
    ib.req0_valid = 1'b0; ib.req0_a = 3'd0; ib.req0_b = 3'd0;
    ib.req1_valid = 1'b0; ib.req1_a = 3'd0; ib.req1_b = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp0_valid: got %0b want 0", ia.rsp0_valid); end
    n_cmp++; if (ia.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp1_valid: got %0b want 0", ia.rsp1_valid); end
    n_cmp++; if (ia.rsp0_result !== 6'd0) begin n_fail++; $display("FAIL reset_rsp0_result: got %0d want 0", ia.rsp0_result); end
    n_cmp++; if (ia.rsp1_result !== 6'd0) begin n_fail++; $display("FAIL reset_rsp1_result: got %0d want 0", ia.rsp1_result); end
    n_cmp++; if (ia.done0_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done0: got %0d want 0", ia.done0_cnt); end
    n_cmp++; if (ia.done1_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done1: got %0d want 0", ia.done1_cnt); end
    n_cmp++; if ({ia.req0_ready, ia.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {ia.req0_ready, ia.req1_ready}); end
    n_cmp++; if ({ia.mul_enable, ia.mul_a, ia.mul_b} !== 7'd0) begin n_fail++; $display("FAIL reset_mul: got %b want 0", {ia.mul_enable, ia.mul_a, ia.mul_b}); end
    n_cmp++; if (ib.done0_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_b_done0: got %0d want 0", ib.done0_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ia.req0_valid = 1'b1; ia.req0_a = 3'd3; ia.req0_b = 3'd5;
    #1;
    n_cmp++; if ({ia.req0_ready, ia.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {ia.req0_ready, ia.req1_ready}); end
    n_cmp++; if ({ia.mul_enable, ia.mul_a, ia.mul_b} !== {1'b1, 3'd3, 3'd5}) begin n_fail++; $display("FAIL single_mul: got en=%0b a=%0d b=%0d want 1 3 5", ia.mul_enable, ia.mul_a, ia.mul_b); end
    tick();
    ia.req0_valid = 1'b0;
    n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got rsp0_valid=%0b want 0", ia.rsp0_valid); end
    tick();
    n_cmp++; if (ia.rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp0_valid: got %0b want 1", ia.rsp0_valid); end
    n_cmp++; if (ia.rsp0_result !== 6'd15) begin n_fail++; $display("FAIL single_rsp0_result: got %0d want 15", ia.rsp0_result); end
    n_cmp++; if ({ia.rsp1_valid, ia.rsp1_result, ia.done1_cnt} !== 15'd0) begin n_fail++; $display("FAIL single_port1_quiet: got v=%0b r=%0d c=%0d want 0 0 0", ia.rsp1_valid, ia.rsp1_result, ia.done1_cnt); end
    tick();
    n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %0b want 0", ia.rsp0_valid); end
    n_cmp++; if (ia.done0_cnt !== 8'd1) begin n_fail++; $display("FAIL single_done0: got %0d want 1", ia.done0_cnt); end
    n_cmp++; if (ia.rsp0_result !== 6'd15) begin n_fail++; $display("FAIL single_result_hold: got %0d want 15", ia.rsp0_result); end
  endtask

  task automatic test_contention();
    int port;
    logic [5:0] exp;
    do_reset();
    ia.req0_valid = 1'b1; ia.req0_a = 3'd7; ia.req0_b = 3'd7;
    ia.req1_valid = 1'b1; ia.req1_a = 3'd2; ia.req1_b = 3'd6;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (ia.req0_ready !== ((i % 2) == 0) || ia.req1_ready !== ((i % 2) == 1)) begin n_fail++; $display("FAIL contention_grant%0d: got %b", i, {ia.req0_ready, ia.req1_ready}); end
      n_cmp++; if (ia.mul_a !== (((i % 2) == 0) ? 3'd7 : 3'd2)) begin n_fail++; $display("FAIL contention_mul_a%0d: got %0d", i, ia.mul_a); end
      tick();
      if (i >= 1) begin
        port = (i - 1) % 2;
        exp  = (port == 0) ? 6'd49 : 6'd12;
        n_cmp++; if ({ia.rsp0_valid, ia.rsp1_valid} !== ((port == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_rsp_valid%0d: got %b port %0d", i - 1, {ia.rsp0_valid, ia.rsp1_valid}, port); end
        n_cmp++; if (((port == 0) ? ia.rsp0_result : ia.rsp1_result) !== exp) begin n_fail++; $display("FAIL contention_rsp_result%0d: got %0d/%0d want %0d", i - 1, ia.rsp0_result, ia.rsp1_result, exp); end
      end
    end
    ia.req0_valid = 1'b0;
    ia.req1_valid = 1'b0;
    tick();
    n_cmp++; if ({ia.rsp0_valid, ia.rsp1_valid} !== 2'b01 || ia.rsp1_result !== 6'd12) begin n_fail++; $display("FAIL contention_last: got v=%b r=%0d want 01 12", {ia.rsp0_valid, ia.rsp1_valid}, ia.rsp1_result); end
    tick();
    n_cmp++; if (ia.done0_cnt !== 8'd4) begin n_fail++; $display("FAIL contention_done0: got %0d want 4", ia.done0_cnt); end
    n_cmp++; if (ia.done1_cnt !== 8'd4) begin n_fail++; $display("FAIL contention_done1: got %0d want 4", ia.done1_cnt); end
  endtask

  task automatic test_sweep();
    logic [5:0] exp;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      ia.req0_valid = 1'b1;
      ia.req0_a = 3'(i / 8);
      ia.req0_b = 3'(i % 8);
      exp_q.push_back(6'((i / 8) * (i % 8)));
      tick();
      if (i >= 1) begin
        exp = exp_q.pop_front();
        n_cmp++; if (ia.rsp0_valid !== 1'b1 || ia.rsp0_result !== exp) begin n_fail++; $display("FAIL sweep_rsp%0d: got v=%0b r=%0d want 1 %0d", i - 1, ia.rsp0_valid, ia.rsp0_result, exp); end
      end
    end
    ia.req0_valid = 1'b0;
    tick();
    exp = exp_q.pop_front();
    n_cmp++; if (ia.rsp0_valid !== 1'b1 || ia.rsp0_result !== exp) begin n_fail++; $display("FAIL sweep_rsp63: got v=%0b r=%0d want 1 %0d", ia.rsp0_valid, ia.rsp0_result, exp); end
    tick();
    n_cmp++; if (ia.done0_cnt !== 8'd64) begin n_fail++; $display("FAIL sweep_done0: got %0d want 64", ia.done0_cnt); end
    n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_tail: got rsp0_valid=%0b want 0", ia.rsp0_valid); end
  endtask

  task automatic test_idle_gaps();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({ia.mul_enable, ia.mul_a, ia.mul_b} !== 7'd0) begin n_fail++; $display("FAIL idle_mul%0d: got %b want 0", i, {ia.mul_enable, ia.mul_a, ia.mul_b}); end
      n_cmp++; if ({ia.rsp0_valid, ia.rsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_rsp%0d: got %b want 00", i, {ia.rsp0_valid, ia.rsp1_valid}); end
      tick();
    end
    ia.req1_valid = 1'b1; ia.req1_a = 3'd4; ia.req1_b = 3'd4;
    #1;
    n_cmp++; if ({ia.req0_ready, ia.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL gap_ready: got %b want 01", {ia.req0_ready, ia.req1_ready}); end
    tick();
    ia.req1_valid = 1'b0;
    n_cmp++; if (ia.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early: got %0b want 0", ia.rsp1_valid); end
    tick();
    n_cmp++; if (ia.rsp1_valid !== 1'b1 || ia.rsp1_result !== 6'd16) begin n_fail++; $display("FAIL gap_rsp1: got v=%0b r=%0d want 1 16", ia.rsp1_valid, ia.rsp1_result); end
    n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL gap_rsp0_quiet: got %0b want 0", ia.rsp0_valid); end
    tick();
  endtask

  task automatic test_reset_midflight();
    ia.req0_valid = 1'b1; ia.req0_a = 3'd6; ia.req0_b = 3'd6;
    tick();
    ia.req0_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (ia.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_pulse%0d: got %0b want 0", i, ia.rsp0_valid); end
    end
    n_cmp++; if (ia.done0_cnt !== 8'd0) begin n_fail++; $display("FAIL midflight_done0: got %0d want 0", ia.done0_cnt); end
    n_cmp++; if (ia.rsp0_result !== 6'd0) begin n_fail++; $display("FAIL midflight_result: got %0d want 0", ia.rsp0_result); end
    ia.req0_valid = 1'b1; ia.req0_a = 3'd1; ia.req0_b = 3'd1;
    ia.req1_valid = 1'b1; ia.req1_a = 3'd1; ia.req1_b = 3'd1;
    #1;
    n_cmp++; if ({ia.req0_ready, ia.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL midflight_first_grant: got %b want 10", {ia.req0_ready, ia.req1_ready}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap_latency3();
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c < 259; c++) begin
      if (c < 256) begin
        ib.req0_valid = 1'b1;
        ib.req0_a = 3'(c % 8);
        ib.req0_b = 3'((c / 8) % 8);
        exp_q.push_back(6'((c % 8) * ((c / 8) % 8)));
      end else begin
        ib.req0_valid = 1'b0;
      end
      tick();
      if (c >= 3) begin
        exp = exp_q.pop_front();
        n_cmp++; if (ib.rsp0_valid !== 1'b1 || ib.rsp0_result !== exp) begin n_fail++; $display("FAIL wrap_rsp%0d: got v=%0b r=%0d want 1 %0d", c - 3, ib.rsp0_valid, ib.rsp0_result, exp); end
      end else begin
        n_cmp++; if (ib.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early%0d: got %0b want 0", c, ib.rsp0_valid); end
      end
      if (c == 257) begin
        n_cmp++; if (ib.done0_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_done255: got %0d want 255", ib.done0_cnt); end
      end
    end
    n_cmp++; if (ib.done0_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_done0: got %0d want 0", ib.done0_cnt); end
    n_cmp++; if (ia.done0_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_a_untouched: got %0d want 0", ia.done0_cnt); end
    tick();
    n_cmp++; if (ib.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_tail: got %0b want 0", ib.rsp0_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_contention();
    test_sweep();
    test_idle_gaps();
    test_reset_midflight();
    test_wrap_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
